// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage_pkg
// Brief   : Load/store encodings, FSM states and helpers for the MEM stage.
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam logic [2:0] NOTLOAD  = 3'd0;
    localparam logic [2:0] LB       = 3'd1;
    localparam logic [2:0] LH       = 3'd2;
    localparam logic [2:0] LW       = 3'd3;
    localparam logic [2:0] LBU      = 3'd4;
    localparam logic [2:0] LHU      = 3'd5;

    localparam logic [1:0] NOTSTORE = 2'd0;
    localparam logic [1:0] SB       = 2'd1;
    localparam logic [1:0] SH       = 2'd2;
    localparam logic [1:0] SW       = 2'd3;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Halfword ops need addr[0] clear, word ops need addr[1:0] clear.
    function automatic logic is_misaligned(input logic [2:0] ld,
                                           input logic [1:0] st,
                                           input logic [1:0] off);
        logic half;
        logic word;
        half = (ld == LH) || (ld == LHU) || (st == SH);
        word = (ld == LW) || (st == SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_extend.sv
`default_nettype none
// ============================================================================
// Module  : load_extend
// Brief   : Byte/halfword lane select with sign or zero extension of load data.
// Revision: 1.0 - initial release
// ============================================================================
module load_extend
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  kind_i,
    output logic [31:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (off_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o = 32'h0;
        case (kind_i)
            LB:      data_o = {{24{w_byte[7]}}, w_byte};
            LH:      data_o = {{16{w_half[15]}}, w_half};
            LW:      data_o = rdata_i;
            LBU:     data_o = {24'h0, w_byte};
            LHU:     data_o = {16'h0, w_half};
            default: data_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage
// Brief   : MEM pipeline stage - data memory req/ack, store lane alignment,
//           load extension, write-back register. Option: MEM_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2E,
    input  logic        write_regE,
    input  logic [2:0]  info_loadE,
    input  logic [1:0]  info_storeE,
    input  logic [4:0]  dstreg_addrE,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_mem,
    output logic [31:0] forward_data_writemem,
    output logic [31:0] forward_data_writeback,
    output logic [31:0] result_W,
    output logic        write_regW,
    output logic [4:0]  dstreg_addrW,
    output logic        misalign_err
);

    mem_state_e  state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        wr_q, wr_d;
    logic [4:0]  dst_q, dst_d;
    logic        err_q, err_d;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_req;
    logic [31:0] w_load_data;

    assign w_mem_op = (info_loadE != NOTLOAD) || (info_storeE != NOTSTORE);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op && is_misaligned(info_loadE, info_storeE, alu_result[1:0]);
`else
    assign w_misalign = FALSE;
`endif

    // Gated by rst_n so the request drops the instant reset asserts.
    assign w_req     = rst_n && w_mem_op && !w_misalign;
    assign stall_mem = w_req && !dmem_ack;

    assign dmem_req  = w_req;
    assign dmem_we   = w_req && (info_storeE != NOTSTORE);
    assign dmem_addr = {alu_result[31:2], 2'b00};

    always_comb begin
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'b0000;
        case (info_storeE)
            SB: begin
                dmem_wdata = {4{rs2E[7:0]}};
                dmem_wstrb = 4'b0001 << alu_result[1:0];
            end
            SH: begin
                dmem_wdata = {2{rs2E[15:0]}};
                dmem_wstrb = alu_result[1] ? 4'b1100 : 4'b0011;
            end
            SW: begin
                dmem_wdata = rs2E;
                dmem_wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

    load_extend u_load_extend (
        .rdata_i (dmem_rdata),
        .off_i   (alu_result[1:0]),
        .kind_i  (info_loadE),
        .data_o  (w_load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_req && !dmem_ack) state_d = WAIT;
            WAIT:    if (!w_req || dmem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stalled or trapped cycles push a bubble; result_W keeps its last value.
    always_comb begin
        result_d = result_q;
        wr_d     = FALSE;
        dst_d    = 5'd0;
        err_d    = FALSE;
        if (w_misalign) begin
            err_d = TRUE;
        end else if (!stall_mem) begin
            result_d = (info_loadE != NOTLOAD) ? w_load_data : alu_result;
            wr_d     = write_regE;
            dst_d    = dstreg_addrE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= 32'h0;
            wr_q     <= FALSE;
            dst_q    <= 5'd0;
            err_q    <= FALSE;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            wr_q     <= wr_d;
            dst_q    <= dst_d;
            err_q    <= err_d;
        end
    end

    assign result_W               = result_q;
    assign write_regW             = wr_q;
    assign dstreg_addrW           = dst_q;
    assign misalign_err           = err_q;
    assign forward_data_writemem  = alu_result;
    assign forward_data_writeback = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_stage
// Brief   : Randomized and directed self-checking bench for mem_access_stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] rs2E = 32'h0;
    logic        write_regE = 1'b0;
    logic [2:0]  info_loadE = 3'd0;
    logic [1:0]  info_storeE = 2'd0;
    logic [4:0]  dstreg_addrE = 5'd0;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_req, dmem_we, stall_mem, write_regW, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, forward_data_writemem, forward_data_writeback, result_W;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  dstreg_addrW;

    int tests = 0;
    int fails = 0;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .rs2E(rs2E),
        .write_regE(write_regE), .info_loadE(info_loadE), .info_storeE(info_storeE),
        .dstreg_addrE(dstreg_addrE), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
        .forward_data_writemem(forward_data_writemem),
        .forward_data_writeback(forward_data_writeback), .result_W(result_W),
        .write_regW(write_regW), .dstreg_addrW(dstreg_addrW), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] f_load(input logic [2:0] k, input logic [1:0] off,
                                           input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = w >> (8 * off);
        sh = w >> (16 * off[1]);
        case (k)
            3'd1: return {{24{sb[7]}}, sb[7:0]};
            3'd2: return {{16{sh[15]}}, sh[15:0]};
            3'd3: return w;
            3'd4: return {24'h0, sb[7:0]};
            3'd5: return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] st, input logic [31:0] d);
        case (st)
            2'd1: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'd2: return {d[15:0], d[15:0]};
            2'd3: return d;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [1:0] st, input logic [1:0] off);
        case (st)
            2'd1: return 4'(1 << off);
            2'd2: return off[1] ? 4'b1100 : 4'b0011;
            2'd3: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic f_mis(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        int size;
        size = 1;
        if (ld == 3'd2 || ld == 3'd5 || st == 2'd2) size = 2;
        if (ld == 3'd3 || st == 2'd3) size = 4;
        return (a % size) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic f_memop();
        return (info_loadE != 3'd0) || (info_storeE != 2'd0);
    endfunction

    logic [31:0] m_result;
    logic        m_wr, m_err;
    logic [4:0]  m_dst;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_result <= 32'h0; m_wr <= 1'b0; m_dst <= 5'd0; m_err <= 1'b0;
        end else if (f_memop() && f_mis(info_loadE, info_storeE, alu_result)) begin
            m_wr <= 1'b0; m_dst <= 5'd0; m_err <= 1'b1;
        end else if (f_memop() && !dmem_ack) begin
            m_wr <= 1'b0; m_dst <= 5'd0; m_err <= 1'b0;
        end else begin
            m_result <= (info_loadE != 3'd0) ? f_load(info_loadE, alu_result[1:0], dmem_rdata)
                                             : alu_result;
            m_wr <= write_regE; m_dst <= dstreg_addrE; m_err <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic ereq;
            ereq = f_memop() && !f_mis(info_loadE, info_storeE, alu_result);
            chk("dmem_req", 32'(dmem_req), 32'(ereq));
            chk("stall_mem", 32'(stall_mem), 32'(ereq && !dmem_ack));
            if (ereq) begin
                chk("dmem_we", 32'(dmem_we), 32'(info_storeE != 2'd0));
                chk("dmem_addr", dmem_addr, {alu_result[31:2], 2'b00});
                chk("dmem_wstrb", 32'(dmem_wstrb), 32'(f_wstrb(info_storeE, alu_result[1:0])));
                if (info_storeE != 2'd0)
                    chk("dmem_wdata", dmem_wdata, f_wdata(info_storeE, rs2E));
            end
            chk("fwd_mem", forward_data_writemem, alu_result);
            chk("result_W", result_W, m_result);
            chk("fwd_wb", forward_data_writeback, m_result);
            chk("write_regW", 32'(write_regW), 32'(m_wr));
            chk("dstreg_addrW", 32'(dstreg_addrW), 32'(m_dst));
            chk("misalign_err", 32'(misalign_err), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] d, input logic wr, input logic [4:0] dst);
        info_loadE = ld; info_storeE = st; alu_result = a; rs2E = d;
        write_regE = wr; dstreg_addrE = dst;
    endtask

    // Called at posedge+1 with the op already driven; ack arrives after nwait cycles.
    task automatic run_op(input int nwait, input logic [31:0] rd, output int stalls);
        stalls = 0;
        for (int k = 0; k <= nwait; k++) begin
            dmem_ack   = (k == nwait);
            dmem_rdata = (k == nwait) ? rd : $urandom;
            #2;
            if (stall_mem) stalls++;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        int st_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset result_W", result_W, 32'h0);
        chk("reset write_regW", 32'(write_regW), 32'h0);
        chk("reset dstreg_addrW", 32'(dstreg_addrW), 32'h0);
        chk("reset dmem_req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;

        // SW, zero wait
        set_op(3'd0, 2'd3, 32'h100, 32'hDEADBEEF, 1'b0, 5'd0);
        dmem_ack = 1'b1; #2;
        chk("SW wstrb", 32'(dmem_wstrb), 32'hF);
        chk("SW addr", dmem_addr, 32'h100);
        chk("SW wdata", dmem_wdata, 32'hDEADBEEF);
        chk("SW stall", 32'(stall_mem), 32'h0);
        @(posedge clk); #1;

        // SB to byte lane 3
        set_op(3'd0, 2'd1, 32'h103, 32'h000000A5, 1'b0, 5'd0);
        #2;
        chk("SB wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("SB wstrb", 32'(dmem_wstrb), 32'h8);
        @(posedge clk); #1;
        dmem_ack = 1'b0;

        // LB / LBU with three wait cycles
        set_op(3'd1, 2'd0, 32'h102, 32'h0, 1'b1, 5'd7);
        run_op(3, 32'h00800000, st_cnt);
        chk("LB stall cycles", st_cnt, 3);
        chk("LB result_W", result_W, 32'hFFFFFF80);
        chk("LB write_regW", 32'(write_regW), 32'h1);
        set_op(3'd4, 2'd0, 32'h102, 32'h0, 1'b1, 5'd7);
        run_op(3, 32'h00800000, st_cnt);
        chk("LBU result_W", result_W, 32'h00000080);

        // ALU pass-through
        set_op(3'd0, 2'd0, 32'h1234, 32'h0, 1'b1, 5'd3);
        #1;
        chk("ADD fwd_mem", forward_data_writemem, 32'h1234);
        chk("ADD no req", 32'(dmem_req), 32'h0);
        @(posedge clk); #1;
        chk("ADD result_W", result_W, 32'h1234);

        // Reset while waiting on memory
        set_op(3'd3, 2'd0, 32'h200, 32'h0, 1'b1, 5'd9);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst dmem_req", 32'(dmem_req), 32'h0);
        chk("rst write_regW", 32'(write_regW), 32'h0);
        set_op(3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
        set_op(3'd3, 2'd0, 32'h101, 32'h0, 1'b1, 5'd4);
        #2;
        chk("trap no req", 32'(dmem_req), 32'h0);
        chk("trap no stall", 32'(stall_mem), 32'h0);
        @(posedge clk); #1;
        chk("trap err", 32'(misalign_err), 32'h1);
        chk("trap write_regW", 32'(write_regW), 32'h0);
        set_op(3'd0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(posedge clk); #1;
        chk("trap err pulse", 32'(misalign_err), 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 120; i++) begin
            int sel, nw;
            logic [2:0] ld;
            logic [1:0] st;
            sel = $urandom_range(0, 9);
            ld = 3'd0; st = 2'd0;
            if (sel >= 2 && sel <= 6) ld = 3'(sel - 1);
            else if (sel >= 7) st = 2'(sel - 6);
            nw = $urandom_range(0, 3);
            set_op(ld, st, $urandom, $urandom, 1'($urandom), 5'($urandom));
            run_op(nw, $urandom, st_cnt);
            if ((ld != 3'd0 || st != 2'd0) && !f_mis(ld, st, alu_result))
                chk("rand stall cycles", st_cnt, nw);
            else
                chk("rand no stall", st_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) pipeline stage: consumes the EX/MEM register outputs of the execute stage and issues loads and stores to the data memory over a req/ack handshake. It holds the pipeline with a stall while memory is busy, aligns store data and byte strobes, and extracts and extends load data. It registers the write-back result and drives both forwarding buses back to execute.

## Interface
- No parameters; data width fixed at 32, register address at 5.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- alu_result  in  32  EX result: memory byte address for loads/stores, else the write-back value
- rs2E  in  32  store source data (already forwarded)
- write_regE  in  1  destination-register write enable
- info_loadE  in  3  load kind
- info_storeE  in  2  store kind
- dstreg_addrE  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes (0000 on loads)
- dmem_ack  in  1  request completed; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  load word
- stall_mem  out  1  freeze IF/ID/EX registers (consumed by the hazard unit)
- forward_data_writemem  out  32  equals alu_result (combinational)
- forward_data_writeback  out  32  equals result_W
- result_W  out  32  write-back value (registered)
- write_regW  out  1  write-back enable (registered)
- dstreg_addrW  out  5  write-back register (registered)
- misalign_err  out  1  one-cycle registered misalignment pulse

## Operation
- Memory op present when info_loadE != NOTLOAD or info_storeE != NOTSTORE. A single op never has both fields set.
- FSM states:
  - IDLE: on a memory op, assert dmem_req combinationally. If dmem_ack arrives the same cycle, the op completes and the FSM stays in IDLE. Otherwise go to WAIT.
  - WAIT: hold dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb stable. On dmem_ack, return to IDLE.
- stall_mem = memory op present AND NOT dmem_ack (combinational, in either state). The EX/MEM inputs are held stable by upstream while stall_mem is high.
- Store lanes:
  - SB: wdata = {4{rs2E[7:0]}}, wstrb = 0001 << alu_result[1:0].
  - SH: wdata = {2{rs2E[15:0]}}, wstrb = alu_result[1] ? 1100 : 0011.
  - SW: wdata = rs2E, wstrb = 1111.
- Loads: select the byte by alu_result[1:0] or the halfword by alu_result[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Write-back register update:
  - Completing cycle (ack, or no memory op): result_W = load data for loads, else alu_result; write_regW = write_regE; dstreg_addrW = dstreg_addrE.
  - Stall cycle: load a bubble (write_regW = 0, dstreg_addrW = 0, result_W holds).
- dmem_ack while dmem_req = 0 is ignored.
- Load-use hazards are not resolved here; the hazard unit inserts a bubble before this stage.

## Timing
- Reset (asynchronous): state = IDLE; result_W = 0, write_regW = 0, dstreg_addrW = 0, misalign_err = 0. dmem_req drops immediately, since all inputs are gated by rst_n.
- Reset asserted while in WAIT: the request is abandoned and no write-back occurs.
- Latency:
  - Zero-wait memory: 1 cycle, no stall.
  - N wait cycles: stall_mem high for N cycles, result visible on result_W one clock after ack.
- Non-memory ops pass through in one cycle.
- forward_data_writemem has zero latency; forward_data_writeback is the registered result_W.

## Configuration
- MEM_MISALIGN_TRAP_EN
  - Defined: a misaligned access (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0) issues no dmem_req and no stall. The stage then writes a bubble and pulses misalign_err high for one cycle, registered.
  - Undefined: no check is made; the low address bits beyond the lane selection are ignored, and misalign_err is tied to 0.

## Structure
- Shared package/define header holds the load/store encodings: NOTLOAD = 0, LB = 1, LH = 2, LW = 3, LBU = 4, LHU = 5; NOTSTORE = 0, SB = 1, SH = 2, SW = 3. It also holds the FSM state constants IDLE/WAIT and the TRUE/FALSE constants.
- One sub-module, load_extend: combinational byte/halfword select plus sign/zero extension.

## Test plan
- SW rs2E = 0xDEADBEEF to address 0x100 with ack in the same cycle -> dmem_wstrb = 1111, dmem_addr = 0x100, stall_mem never high.
- SB rs2E = 0x000000A5 to address 0x103 -> dmem_wdata = 0xA5A5A5A5, dmem_wstrb = 1000.
- LB at 0x102 with rdata 0x0080_0000, ack delayed 3 cycles -> stall_mem high for 3 cycles, and in the following cycle result_W = 0xFFFFFF80 with write_regW = 1. The same access as LBU -> result_W = 0x00000080.
- ADD result 0x1234 with write_regE = 1 -> forward_data_writemem = 0x1234 immediately; result_W = 0x1234 next cycle; no dmem_req.
- rst_n low while in WAIT -> dmem_req = 0 at once, write_regW = 0, state returns to IDLE.
- With MEM_MISALIGN_TRAP_EN defined, LW at 0x101 -> no dmem_req, misalign_err = 1 for one cycle, write_regW = 0.
